// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 4x8 register file: initialisation pass after reset,
// then round-robin sharing between the core writeback (A) and the debug loader (B).
module rf_write_arbiter #(
    parameter int unsigned         DATA_W     = 8,
    parameter int unsigned         ADDR_W     = 2,
    parameter logic [DATA_W-1:0]   INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              init_done,
    output logic [7:0]        conflict_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef enum logic {GNT_A, GNT_B} grant_t;

    state_t              state_q, state_d;
    grant_t              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   init_idx_q, init_idx_d;
    logic                we_d;
    logic [ADDR_W-1:0]   waddr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                init_done_d;
    logic [7:0]          conflict_d;
    logic                grant_a, grant_b;

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_INIT;
            last_grant_q   <= GNT_B;
            init_idx_q     <= '0;
            write_enable   <= 1'b0;
            write_addr     <= '0;
            write_data     <= '0;
            init_done      <= 1'b0;
            conflict_count <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            init_idx_q     <= init_idx_d;
            write_enable   <= we_d;
            write_addr     <= waddr_d;
            write_data     <= wdata_d;
            init_done      <= init_done_d;
            conflict_count <= conflict_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        init_idx_d   = init_idx_q;
        we_d         = 1'b0;
        waddr_d      = write_addr;
        wdata_d      = write_data;
        init_done_d  = init_done;
        conflict_d   = conflict_count;
        grant_a      = 1'b0;
        grant_b      = 1'b0;

        case (state_q)
            ST_INIT: begin
                we_d       = 1'b1;
                waddr_d    = init_idx_q;
                wdata_d    = INIT_VALUE;
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                // On a tie the requester that did not win last time is served.
                if (a_valid && b_valid) begin
                    grant_a = (last_grant_q == GNT_B);
                    grant_b = (last_grant_q == GNT_A);
                    if (conflict_count != 8'hFF)
                        conflict_d = conflict_count + 8'd1;
                end else begin
                    grant_a = a_valid;
                    grant_b = b_valid;
                end

                if (grant_a) begin
                    we_d         = 1'b1;
                    waddr_d      = a_addr;
                    wdata_d      = a_data;
                    last_grant_d = GNT_A;
                end else if (grant_b) begin
                    we_d         = 1'b1;
                    waddr_d      = b_addr;
                    wdata_d      = b_data;
                    last_grant_d = GNT_B;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

endmodule
